// File: rtl/rc_adder_pkg.sv
// Shared types and sizing helpers for the serial adder built around the
// 2-bit ripple-carry slice.
package rc_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n digit cycles; a single digit still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rc_adder.sv
// Combinational 2-bit ripple-carry slice: {cout, sum1, sum0} = {a1,a0} + {b1,b0} + c.
module rc_adder (
  input  logic a1,
  input  logic b1,
  input  logic a0,
  input  logic b0,
  input  logic c,
  output logic sum1,
  output logic sum0,
  output logic cout
);

  logic c0;

  assign sum0 = a0 ^ b0 ^ c;
  assign c0   = (a0 & b0) | (c & (a0 ^ b0));
  assign sum1 = a1 ^ b1 ^ c0;
  assign cout = (a1 & b1) | (c0 & (a1 ^ b1));

endmodule

// File: rtl/rc_serial_adder.sv
// Serial adder: feeds one 2-bit digit pair per cycle through a single rc_adder
// slice, LSB digit first, and presents {cout, sum} behind valid/ready handshakes.
module rc_serial_adder
  import rc_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready depends only on state.
  localparam int N     = WIDTH / 2;
  localparam int CNT_W = cnt_width(N);

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               s1, s0, sc;
  logic               last;

  rc_adder u_slice (
    .a1   (a_sh[1]),
    .b1   (b_sh[1]),
    .a0   (a_sh[0]),
    .b0   (b_sh[0]),
    .c    (carry),
    .sum1 (s1),
    .sum0 (s0),
    .cout (sc)
  );

  assign last = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 2;
          b_sh   <= b_sh >> 2;
          // New digit enters at the top; after N shifts it sits at the LSBs.
          sum_sh <= WIDTH'({s1, s0, sum_sh} >> 2);
          carry  <= sc;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry;

endmodule

// File: tb/tb_rc_serial_adder.sv
// Bench for rc_serial_adder at WIDTH=8 and WIDTH=2: directed cases plus
// randomized back-to-back traffic checked through per-instance expected queues.
module tb_rc_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv8 = 1'b0, or8 = 1'b1, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, co8;
  logic [7:0] s8;

  logic       iv2 = 1'b0, or2 = 1'b1, ci2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ir2, ov2, co2;
  logic [1:0] s2;

  logic [8:0] exp_q8[$];
  logic [2:0] exp_q2[$];
  logic [8:0] e8;
  logic [2:0] e2;

  int  n_cmp = 0;
  int  n_mis = 0;
  bit  rnd_en = 1'b0;

  rc_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
  );

  rc_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(ci2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge
  task automatic send(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic c);
    int t;
    t = 0;
    @(posedge clk); #1;
    if (sel) begin a2 = a[1:0]; b2 = b[1:0]; ci2 = c; iv2 = 1'b1; end
    else     begin a8 = a;      b8 = b;      ci8 = c; iv8 = 1'b1; end
    do begin
      @(negedge clk);
      t++;
    end while (!(sel ? ir2 : ir8) && t < 200);
    if (sel) chk("accept2", ir2, 1'b1);
    else     chk("accept8", ir8, 1'b1);
    @(posedge clk); #1;
    if (sel) iv2 = 1'b0;
    else     iv8 = 1'b0;
  endtask

  // Returns the number of cycles from acceptance until out_valid is seen.
  task automatic wait_out(input bit sel, output int lat);
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel ? ov2 : ov8) && lat < 50);
  endtask

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      or8 = 1'($urandom_range(0, 1));
      or2 = 1'($urandom_range(0, 1));
    end
  end

  // scoreboards
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q8.delete();
    end else begin
      if (iv8 && ir8) exp_q8.push_back({1'b0, a8} + {1'b0, b8} + {8'b0, ci8});
      if (ov8 && or8) begin
        if (exp_q8.size() == 0) chk("spurious8", ov8, 1'b0);
        else begin
          e8 = exp_q8.pop_front();
          chk("sb8", {co8, s8}, e8);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q2.delete();
    end else begin
      if (iv2 && ir2) exp_q2.push_back({1'b0, a2} + {1'b0, b2} + {2'b0, ci2});
      if (ov2 && or2) begin
        if (exp_q2.size() == 0) chk("spurious2", ov2, 1'b0);
        else begin
          e2 = exp_q2.pop_front();
          chk("sb2", {co2, s2}, e2);
        end
      end
    end
  end

  initial begin
    int       lat;
    int       t;
    logic [7:0] held_s;
    logic       held_c;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ir8, 1'b1);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_sum", s8, 8'h00);
    chk("rst_cout", co8, 1'b0);

    // basic add, latency and return of in_ready
    send(0, 8'h5A, 8'h3C, 1'b0);
    wait_out(0, lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", s8, 8'h96);
    chk("t1_cout", co8, 1'b0);
    chk("t1_in_ready_done", ir8, 1'b0);
    @(negedge clk);
    chk("t1_out_valid_1cyc", ov8, 1'b0);
    chk("t1_in_ready_back", ir8, 1'b1);

    send(0, 8'hFF, 8'h01, 1'b0);
    wait_out(0, lat);
    chk("t2_sum", s8, 8'h00);
    chk("t2_cout", co8, 1'b1);
    send(0, 8'hFF, 8'hFF, 1'b1);
    wait_out(0, lat);
    chk("t3_sum", s8, 8'hFF);
    chk("t3_cout", co8, 1'b1);

    // backpressure with an ignored in_valid while the result is held
    @(posedge clk); #1 or8 = 1'b0;
    send(0, 8'h12, 8'h34, 1'b1);
    wait_out(0, lat);
    chk("bp_latency", lat, 4);
    chk("bp_sum", s8, 8'h47);
    held_s = s8;
    held_c = co8;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      iv8 = 1'b1;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      @(negedge clk);
      chk("bp_valid_hold", ov8, 1'b1);
      chk("bp_sum_hold", s8, held_s);
      chk("bp_cout_hold", co8, held_c);
      chk("bp_in_ready", ir8, 1'b0);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    chk("bp_valid_pending", ov8, 1'b1);
    @(negedge clk);
    chk("bp_valid_taken", ov8, 1'b0);
    chk("bp_idle", ir8, 1'b1);
    repeat (8) @(negedge clk);
    chk("bp_no_ghost", ov8, 1'b0);

    // reset in the middle of RUN
    send(0, 8'hAA, 8'h55, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_in_ready", ir8, 1'b1);
    chk("mr_out_valid", ov8, 1'b0);
    chk("mr_sum", s8, 8'h00);
    chk("mr_cout", co8, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    send(0, 8'h10, 8'h20, 1'b0);
    wait_out(0, lat);
    chk("mr_latency", lat, 4);
    chk("mr_sum_after", s8, 8'h30);
    chk("mr_cout_after", co8, 1'b0);

    // smallest width: one digit cycle
    send(1, 8'h03, 8'h03, 1'b1);
    wait_out(1, lat);
    chk("w2_latency", lat, 1);
    chk("w2_sum", s2, 2'd3);
    chk("w2_cout", co2, 1'b1);
    @(negedge clk);
    chk("w2_in_ready_back", ir2, 1'b1);

    // random back-to-back traffic on both widths
    @(posedge clk); #1 rnd_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          send(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join
    rnd_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    or8 = 1'b1;
    or2 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q8.size() != 0 || exp_q2.size() != 0) && t < 100);
    chk("drain8", exp_q8.size(), 0);
    chk("drain2", exp_q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
